// File: rtl/ch3_wt_pkg.sv
// rtl/ch3_wt_pkg.sv - shared state encoding, blank code and default sizing for the CH3 display scan
package ch3_wt_pkg;

  typedef enum logic [1:0] {
    WT_IDLE  = 2'd0,
    WT_BLANK = 2'd1,
    WT_DRIVE = 2'd2
  } wt_state_t;

  // Code the 7-segment decoder renders as all segments off
  localparam logic [3:0] WT_BLANK_CODE = 4'hF;

  localparam int WT_DIGITS_DEF = 6;
  localparam int WT_DIV_DEF    = 1000;
  localparam int WT_BLANK_DEF  = 50;

  function automatic int wt_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ch3_wt_scan_tick.sv
// rtl/ch3_wt_scan_tick.sv - per-slot clock counter with terminal-count and blank-end strobes
module ch3_wt_scan_tick
  import ch3_wt_pkg::*;
#(
  parameter int DIV   = WT_DIV_DEF,
  parameter int BLANK = WT_BLANK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic tc,
  output logic blank_end
);

  localparam int              CW     = wt_clog2_min1(DIV);
  localparam logic [CW-1:0]   TC_VAL = CW'(DIV - 1);
  localparam logic [CW-1:0]   BE_VAL = CW'((BLANK > 0) ? BLANK - 1 : 0);

  logic [CW-1:0] cnt;

  // Held at zero while idle so the first slot of a frame starts from 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!en || hold || tc)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tc        = (cnt == TC_VAL);
  assign blank_end = (BLANK > 0) && (cnt == BE_VAL);

endmodule

// File: rtl/ch3_wt_scan_ctrl.sv
// rtl/ch3_wt_scan_ctrl.sv - multiplexed digit scan with per-slot anti-ghost blanking
// Define WT_SCAN_LZB_EN to blank the most significant digit when it is zero.
module ch3_wt_scan_ctrl
  import ch3_wt_pkg::*;
#(
  parameter int DIGITS = WT_DIGITS_DEF,
  parameter int DIV    = WT_DIV_DEF,
  parameter int BLANK  = WT_BLANK_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dot_in,
  output logic [3:0]            bcd,
  output logic                  dot,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int              IW         = wt_clog2_min1(DIGITS);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(DIGITS - 1);
  localparam wt_state_t       SLOT_START = (BLANK == 0) ? WT_DRIVE : WT_BLANK;

  wt_state_t             state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0]     snap_dot_q, snap_dot_d;
  logic                  load;
  logic                  frame_d;
  logic                  tc, blank_end;
  logic [3:0]            digit_d;
  logic                  blank_digit;
  logic                  drive_d;
  logic [3:0]            bcd_d;
  logic                  dot_d;
  logic [DIGITS-1:0]     sel_d;

  ch3_wt_scan_tick #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hold      (state_q == WT_IDLE),
    .tc        (tc),
    .blank_end (blank_end)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    frame_d = 1'b0;
    if (!en) begin
      state_d = WT_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        WT_IDLE: begin
          state_d = SLOT_START;
          idx_d   = '0;
          load    = 1'b1;
          frame_d = 1'b1;
        end
        WT_BLANK: begin
          if (blank_end)
            state_d = WT_DRIVE;
        end
        WT_DRIVE: begin
          if (tc) begin
            state_d = SLOT_START;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              load    = 1'b1;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: state_d = WT_IDLE;
      endcase
    end
  end

  // Outputs are computed from the post-edge state so they can be registered
  always_comb begin
    snap_bcd_d = load ? bcd_in : snap_bcd_q;
    snap_dot_d = load ? dot_in : snap_dot_q;
    digit_d    = snap_bcd_d[{idx_d, 2'b00} +: 4];
`ifdef WT_SCAN_LZB_EN
    blank_digit = (idx_d == LAST_IDX) && (digit_d == 4'd0);
`else
    blank_digit = 1'b0;
`endif
    drive_d = (state_d == WT_DRIVE) && !blank_digit;
    bcd_d   = drive_d ? digit_d : WT_BLANK_CODE;
    dot_d   = drive_d && snap_dot_d[idx_d];
    sel_d   = drive_d ? (DIGITS'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WT_IDLE;
      idx_q       <= '0;
      snap_bcd_q  <= '0;
      snap_dot_q  <= '0;
      bcd         <= WT_BLANK_CODE;
      dot         <= 1'b0;
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_bcd_q  <= snap_bcd_d;
      snap_dot_q  <= snap_dot_d;
      bcd         <= bcd_d;
      dot         <= dot_d;
      digit_sel   <= sel_d;
      frame_start <= frame_d;
    end
  end

endmodule

// File: tb/tb_ch3_wt_scan_ctrl.sv
// tb/tb_ch3_wt_scan_ctrl.sv - vector table, corner sequences and randomized model check for the scan controller
module tb_ch3_wt_scan_ctrl;

  localparam int DIGITS = 6;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        en     = 1'b0;
  logic [23:0] bcd_in = '0;
  logic [5:0]  dot_in = '0;
  logic [3:0]  bcd;
  logic        dot;
  logic [5:0]  digit_sel;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within the frame plus a captured snapshot
  bit          m_active = 1'b0;
  int          m_p      = 0;
  logic [23:0] m_bcd    = '0;
  logic [5:0]  m_dot    = '0;

  typedef struct {
    logic        en;
    logic [23:0] bcd;
    logic [5:0]  dot;
    int          ncyc;
    logic [5:0]  sel;
    logic [3:0]  bcd_o;
    logic        dot_o;
    logic        fs;
  } vec_t;

  vec_t tbl [12];

  ch3_wt_scan_ctrl #(
    .DIGITS (DIGITS),
    .DIV    (DIV),
    .BLANK  (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bcd_in      (bcd_in),
    .dot_in      (dot_in),
    .bcd         (bcd),
    .dot         (dot),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [5:0] sel, input logic [3:0] b,
                           input logic d, input logic fs);
    chk($sformatf("%s.sel", name), 32'(digit_sel), 32'(sel));
    chk($sformatf("%s.bcd", name), 32'(bcd), 32'(b));
    chk($sformatf("%s.dot", name), 32'(dot), 32'(d));
    chk($sformatf("%s.fs", name), 32'(frame_start), 32'(fs));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst || !en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_p      = 0;
      m_bcd    = bcd_in;
      m_dot    = dot_in;
    end else begin
      m_p = (m_p + 1) % FRAME;
      if (m_p == 0) begin
        m_bcd = bcd_in;
        m_dot = dot_in;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_model(input string name);
    logic [5:0] es;
    logic [3:0] eb;
    logic       ed;
    logic       ef;
    logic [3:0] dg;
    bit         hide;
    int         slot;
    int         off;
    es = '0; eb = 4'hF; ed = 1'b0; ef = 1'b0;
    if (m_active) begin
      slot = m_p / DIV;
      off  = m_p % DIV;
      ef   = (m_p == 0);
      dg   = 4'(m_bcd >> (4 * slot));
`ifdef WT_SCAN_LZB_EN
      hide = (slot == DIGITS - 1) && (dg == 4'd0);
`else
      hide = 1'b0;
`endif
      if (off >= BLANK && !hide) begin
        es = 6'(1 << slot);
        eb = dg;
        ed = m_dot[slot];
      end
    end
    check_out(name, es, eb, ed, ef);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 24'h123456, 6'b000100, 1,  6'b000000, 4'hF, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 24'h123456, 6'b000100, 1,  6'b000000, 4'hF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 24'h123456, 6'b000100, 1,  6'b000001, 4'h6, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 24'h123456, 6'b000100, 5,  6'b000001, 4'h6, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 24'h123456, 6'b000100, 1,  6'b000000, 4'hF, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 24'h123456, 6'b000100, 2,  6'b000010, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 24'h123456, 6'b000100, 8,  6'b000100, 4'h4, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 24'h123456, 6'b000100, 8,  6'b001000, 4'h3, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 24'h123456, 6'b000100, 16, 6'b100000, 4'h1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 24'h123456, 6'b000100, 5,  6'b100000, 4'h1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 24'h123456, 6'b000100, 1,  6'b000000, 4'hF, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 24'h123456, 6'b000100, 1,  6'b000000, 4'hF, 1'b0, 1'b0};

    // Reset with random inputs
    #1 rst = 1'b1;
    en     = 1'($urandom);
    bcd_in = 24'($urandom);
    dot_in = 6'($urandom);
    run(3);
    check_out("reset", 6'b0, 4'hF, 1'b0, 1'b0);
    en  = 1'b0;
    rst = 1'b0;
    run(1);
    check_out("idle", 6'b0, 4'hF, 1'b0, 1'b0);

    // Basic frame from the vector table
    for (int i = 0; i < 12; i++) begin
      en     = tbl[i].en;
      bcd_in = tbl[i].bcd;
      dot_in = tbl[i].dot;
      run(tbl[i].ncyc);
      check_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].bcd_o, tbl[i].dot_o, tbl[i].fs);
    end

    // Snapshot holds through a mid-frame input change
    en = 1'b1; bcd_in = 24'h123456; dot_in = 6'b0;
    run(1);
    check_out("snap.start", 6'b0, 4'hF, 1'b0, 1'b1);
    run(26);
    check_out("snap.s3", 6'b001000, 4'h3, 1'b0, 1'b0);
    bcd_in = 24'h999999;
    run(1);
    check_out("snap.s3b", 6'b001000, 4'h3, 1'b0, 1'b0);
    run(8);
    check_out("snap.s4", 6'b010000, 4'h2, 1'b0, 1'b0);
    run(8);
    check_out("snap.s5", 6'b100000, 4'h1, 1'b0, 1'b0);
    run(5);
    check_out("snap.wrap", 6'b0, 4'hF, 1'b0, 1'b1);
    run(2);
    check_out("snap.n0", 6'b000001, 4'h9, 1'b0, 1'b0);
    run(8);
    check_out("snap.n1", 6'b000010, 4'h9, 1'b0, 1'b0);

    // EN drop in slot 2, then restart
    en = 1'b0;
    run(2);
    en = 1'b1; bcd_in = 24'h123456; dot_in = 6'b000100;
    run(19);
    check_out("endrop.s2", 6'b000100, 4'h4, 1'b1, 1'b0);
    en = 1'b0;
    run(1);
    check_out("endrop.idle", 6'b0, 4'hF, 1'b0, 1'b0);
    run(3);
    check_out("endrop.hold", 6'b0, 4'hF, 1'b0, 1'b0);
    en = 1'b1;
    run(1);
    check_out("endrop.fs", 6'b0, 4'hF, 1'b0, 1'b1);
    run(2);
    check_out("endrop.d0", 6'b000001, 4'h6, 1'b0, 1'b0);

    // Asynchronous reset between edges mid-drive
    run(8);
    check_out("arst.pre", 6'b000010, 4'h5, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_out("arst.async", 6'b0, 4'hF, 1'b0, 1'b0);
    m_active = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    run(1);
    check_out("arst.fs", 6'b0, 4'hF, 1'b0, 1'b1);
    run(2);
    check_out("arst.d0", 6'b000001, 4'h6, 1'b0, 1'b0);

    // Leading-zero digit
    en = 1'b0;
    run(2);
    en = 1'b1; bcd_in = 24'h012345; dot_in = 6'b0;
    run(35);
    check_out("lzb.s4", 6'b010000, 4'h1, 1'b0, 1'b0);
    run(8);
`ifdef WT_SCAN_LZB_EN
    check_out("lzb.s5a", 6'b0, 4'hF, 1'b0, 1'b0);
    run(5);
    check_out("lzb.s5b", 6'b0, 4'hF, 1'b0, 1'b0);
`else
    check_out("lzb.s5a", 6'b100000, 4'h0, 1'b0, 1'b0);
    run(5);
    check_out("lzb.s5b", 6'b100000, 4'h0, 1'b0, 1'b0);
`endif

    // Randomized run against the frame-position model
    en = 1'b0;
    run(2);
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 99) < 98);
      if ($urandom_range(0, 7) == 0) begin
        bcd_in = 24'($urandom);
        if ($urandom_range(0, 3) == 0)
          bcd_in[23:20] = 4'h0;
      end
      if ($urandom_range(0, 7) == 0)
        dot_in = 6'($urandom);
      run(1);
      check_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ch3_wt_scan_ctrl.md
# ch3_wt_scan_ctrl

Time-multiplexed display scan controller for the CH3 watch. It sits between the time-keeping registers and the BCD-to-7-segment decoder, which takes a 4-bit BCD code plus a DOT bit. The block snapshots all digit values at frame start and steps through the digits one slot at a time, presenting one BCD code and DOT bit to the decoder while driving a one-hot digit select. Each slot begins with an anti-ghosting blank interval.

## Interface
- DIGITS, 6: number of digits; digit 0 is the rightmost (seconds ones).
- DIV, 1000: clocks per digit slot; legal when DIV ≥ 2.
- BLANK, 50: blank clocks at the start of each slot; legal when 0 ≤ BLANK < DIV.

- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  scan enable, level-sensitive.
- BCD_IN  in  4*DIGITS  packed digit values; digit i is in BCD_IN[4i+3:4i].
- DOT_IN  in  DIGITS  per-digit decimal point; bit i belongs to digit i.
- BCD  out  4  code to the decoder; 4'hF while blanked, which decodes to all segments off.
- DOT  out  1  decimal point to the decoder.
- DIGIT_SEL  out  DIGITS  one-hot, active-high digit enable; all zero while blanked.
- FRAME_START  out  1  one-clock pulse in the first cycle of each frame.

## Operation
- States:
  - IDLE: outputs blanked, counters held at 0.
  - BLANK: outputs blanked.
  - DRIVE: DIGIT_SEL[idx]=1, BCD and DOT taken from the snapshot for digit idx.
- Counters:
  - slot counter cnt, width clog2(DIV).
  - digit index idx, width clog2(DIGITS).
- Transitions:
  - IDLE→BLANK when EN=1. On this transition: idx=0, cnt=0, snapshot loaded, FRAME_START=1. If BLANK=0, go straight to DRIVE instead.
  - BLANK→DRIVE when cnt==BLANK-1. cnt keeps counting across the transition.
  - DRIVE→BLANK (or DRIVE→DRIVE when BLANK=0) when cnt==DIV-1. On this transition: cnt=0 and idx increments.
  - idx wraps from DIGITS-1 to 0. The wrap reloads the snapshot and pulses FRAME_START.
  - Any state→IDLE on the clock after EN is sampled 0. This overrides all other transitions.
- Snapshot: BCD_IN and DOT_IN are captured only at frame start. Input changes mid-frame have no visible effect until the next frame.
- Snapshot BCD values above 9 pass through unchanged; the decoder blanks them.
- Reset values: state IDLE, cnt 0, idx 0, snapshot 0, BCD 4'hF, DOT 0, DIGIT_SEL 0, FRAME_START 0.

## Timing
- All outputs are registered and change only on CLK rising edges, except on RST assertion, which clears them immediately.
- Slot length is exactly DIV clocks: BLANK blanked clocks followed by DIV-BLANK driven clocks.
- Frame length is DIGITS×DIV clocks.
- First-frame latency: EN sampled high at edge k gives FRAME_START=1 in cycle k+1. DIGIT_SEL[0] first asserts in cycle k+1+BLANK.
- DIGIT_SEL never has two bits set, and never changes directly from one digit to another when BLANK>0.
- RST deasserted while EN=1: start-up behaves exactly like an EN rise.

## Configuration
- WT_SCAN_LZB_EN: leading-zero blanking.
  - Defined: in the slot for digit DIGITS-1, if its snapshot BCD is 0, the slot behaves as BLANK for its full length (DIGIT_SEL=0, BCD=4'hF, DOT=0). Slot timing is unchanged.
  - Undefined: that digit displays 0 normally.

## Structure
- Shared package ch3_wt_pkg holds:
  - the state encoding constants (IDLE, BLANK, DRIVE);
  - the blank code constant 4'hF;
  - the default DIGITS, DIV and BLANK values.
- One sub-module, ch3_wt_scan_tick: slot counter plus terminal-count and blank-end strobes, with synchronous clear driven by EN=0.

## Test plan
All scenarios use DIV=8, BLANK=2, DIGITS=6.
- Reset: RST=1 with random inputs → BCD=F, DOT=0, DIGIT_SEL=0, FRAME_START=0.
- Basic frame: EN rises, BCD_IN=0x123456, DOT_IN=6'b000100 →
  - FRAME_START pulses once, followed by 2 blank clocks.
  - Then 6 clocks of SEL=000001, BCD=6.
  - Slot 2 drives SEL=000100, BCD=4, DOT=1.
  - Slot 5 drives SEL=100000, BCD=1.
  - The next FRAME_START comes 48 clocks after the first.
- Snapshot: change BCD_IN to 0x999999 during slot 3 → slots 3–5 still show 3,2,1; the following frame shows all 9s.
- EN drop: EN=0 during DRIVE of slot 2 → IDLE outputs next clock. EN=1 later → frame restarts at digit 0 with a new FRAME_START.
- Async reset: RST pulsed mid-DRIVE, between clock edges → DIGIT_SEL=0 and BCD=F before the next edge; scan restarts at digit 0 after release.
- LZB: BCD_IN=0x012345.
  - With WT_SCAN_LZB_EN → slot 5 has SEL=0, BCD=F for 8 clocks.
  - Without it → slot 5 shows SEL=100000, BCD=0.
